// File: rtl/bitslip_align_multi_if.sv
// rtl/bitslip_align_multi_if.sv - Aligner bus: enable, deserialised words, bitslip and status flags.
interface bitslip_align_multi_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    logic                 EN;
    logic [NCH*WIDTH-1:0] data_in;
    logic [NCH-1:0]       BS;
    logic [NCH-1:0]       locked;
    logic [NCH-1:0]       fail;
    logic                 all_locked;
    logic                 any_fail;
    logic [NCH-1:0]       lol;

    modport master (
        output EN, data_in,
        input  BS, locked, fail, all_locked, any_fail, lol
    );

    modport slave (
        input  EN, data_in,
        output BS, locked, fail, all_locked, any_fail, lol
    );
endinterface

// File: rtl/bitslip_align_multi.sv
// rtl/bitslip_align_multi.sv - Per-channel ISERDESE2 bitslip word aligner with aggregated lock/fail status.
// Optional re-alignment on loss of lock: define LOSS_OF_LOCK_EN.
module bitslip_align_multi #(
    parameter int               WIDTH            = 8,
    parameter int               NCH              = 4,
    parameter logic [WIDTH-1:0] TRAINING_PATTERN = 8'hF0,
    parameter int               WAIT_CYCLES      = 5,
    parameter int               MATCH_COUNT      = 4,
    parameter int               MAX_SLIPS        = 16,
    parameter int               LOL_THRESH       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    bitslip_align_multi_if.slave   bus
);
    localparam int SW = $clog2(MAX_SLIPS + 1);
    localparam int WW = $clog2(WAIT_CYCLES + 1);
    localparam int MW = $clog2(MATCH_COUNT + 1);

    localparam logic [SW-1:0] SLIP_MAX   = SW'(MAX_SLIPS);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_CYCLES - 1);
    localparam logic [MW-1:0] MATCH_MAX  = MW'(MATCH_COUNT);
    localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SLIP,
        S_WAIT,
        S_LOCKED,
        S_FAIL
    } state_t;

    if (WAIT_CYCLES < 1 || MATCH_COUNT < 1 || MAX_SLIPS < WIDTH || LOL_THRESH < 1) begin : g_bad_params
        $error("bitslip_align_multi: illegal parameter set");
    end

    logic [NCH-1:0] bs_vec;
    logic [NCH-1:0] locked_vec;
    logic [NCH-1:0] fail_vec;
    logic [NCH-1:0] lol_vec;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        state_t           state_q;
        logic [SW-1:0]    slip_cnt_q;
        logic [WW-1:0]    wait_cnt_q;
        logic [MW-1:0]    match_cnt_q;
        logic             bs_q;
        logic             locked_q;
        logic             fail_q;
        logic             hit;

        assign hit = (bus.data_in[k*WIDTH +: WIDTH] == TRAINING_PATTERN);

`ifdef LOSS_OF_LOCK_EN
        localparam int            EW       = $clog2(LOL_THRESH + 1);
        localparam logic [EW-1:0] ERR_LAST = EW'(LOL_THRESH - 1);
        logic [EW-1:0] err_cnt_q;
        logic          lol_q;
`endif

        always_ff @(posedge clk) begin
            // BS and lol are pulses: only the transitions below may raise them for a cycle
            bs_q <= 1'b0;
`ifdef LOSS_OF_LOCK_EN
            lol_q <= 1'b0;
`endif
            if (rst || !bus.EN) begin
                state_q     <= S_IDLE;
                slip_cnt_q  <= '0;
                wait_cnt_q  <= '0;
                match_cnt_q <= '0;
                locked_q    <= 1'b0;
                fail_q      <= 1'b0;
`ifdef LOSS_OF_LOCK_EN
                err_cnt_q   <= '0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: state_q <= S_CHECK;
                    S_CHECK: begin
                        if (hit) begin
                            if (match_cnt_q == MATCH_LAST) begin
                                match_cnt_q <= MATCH_MAX;
                                locked_q    <= 1'b1;
                                state_q     <= S_LOCKED;
`ifdef LOSS_OF_LOCK_EN
                                err_cnt_q   <= '0;
`endif
                            end else if (match_cnt_q != MATCH_MAX) begin
                                match_cnt_q <= match_cnt_q + 1'b1;
                            end
                        end else begin
                            match_cnt_q <= '0;
                            if (slip_cnt_q == SLIP_MAX) begin
                                fail_q  <= 1'b1;
                                state_q <= S_FAIL;
                            end else begin
                                bs_q    <= 1'b1;
                                state_q <= S_SLIP;
                            end
                        end
                    end
                    S_SLIP: begin
                        if (slip_cnt_q != SLIP_MAX) slip_cnt_q <= slip_cnt_q + 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (wait_cnt_q == WAIT_LAST) begin
                            wait_cnt_q <= '0;
                            state_q    <= S_CHECK;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                    end
                    S_LOCKED: begin
`ifdef LOSS_OF_LOCK_EN
                        if (hit) begin
                            err_cnt_q <= '0;
                        end else if (err_cnt_q == ERR_LAST) begin
                            err_cnt_q   <= '0;
                            slip_cnt_q  <= '0;
                            match_cnt_q <= '0;
                            locked_q    <= 1'b0;
                            lol_q       <= 1'b1;
                            state_q     <= S_CHECK;
                        end else begin
                            err_cnt_q <= err_cnt_q + 1'b1;
                        end
`endif
                    end
                    S_FAIL: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end

        assign bs_vec[k]     = bs_q;
        assign locked_vec[k] = locked_q;
        assign fail_vec[k]   = fail_q;
`ifdef LOSS_OF_LOCK_EN
        assign lol_vec[k]    = lol_q;
`else
        assign lol_vec[k]    = 1'b0;
`endif
    end

    assign bus.BS         = bs_vec;
    assign bus.locked     = locked_vec;
    assign bus.fail       = fail_vec;
    assign bus.lol        = lol_vec;
    assign bus.all_locked = &locked_vec;
    assign bus.any_fail   = |fail_vec;
endmodule

// File: tb/tb_bitslip_align_multi.sv
// tb/tb_bitslip_align_multi.sv - Directed bench for bitslip_align_multi with a rotating-word ISERDES model.
module tb_bitslip_align_multi;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bitslip_align_multi_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();
    bitslip_align_multi #(.WIDTH(WIDTH), .NCH(NCH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int passed = 0;
    int total  = 0;
    int cyc;
    int rot[NCH];
    bit cmode[NCH];
    logic [7:0] cval[NCH];
    int gtick[NCH];
    logic [7:0] gval[NCH];
    int bs_cnt[NCH];
    int pulse_tick[NCH][20];
    int lock_tick[NCH];
    int fail_tick[NCH];
    int lol_cnt[NCH];

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int r);
        int rr;
        rr = r % 8;
        return (v << rr) | (v >> (8 - rr));
    endfunction

    task automatic drive_data();
        logic [7:0] w;
        for (int k = 0; k < NCH; k++) begin
            if (cmode[k]) w = (gtick[k] == cyc) ? gval[k] : cval[k];
            else          w = rotl8(8'hF0, rot[k]);
            bus.data_in[k*WIDTH +: WIDTH] = w;
        end
    endtask

    // Sample #1 after the edge; a BS pulse seen here rotates that channel's word from now on
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NCH; k++) begin
            if (bus.BS[k]) begin
                if (bs_cnt[k] < 20) pulse_tick[k][bs_cnt[k]] = cyc;
                bs_cnt[k]++;
                if (!cmode[k]) rot[k]++;
            end
            if (bus.locked[k] && lock_tick[k] < 0) lock_tick[k] = cyc;
            if (bus.fail[k] && fail_tick[k] < 0) fail_tick[k] = cyc;
            if (bus.lol[k]) lol_cnt[k]++;
        end
        drive_data();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic default_cfg();
        for (int k = 0; k < NCH; k++) begin
            rot[k] = 0; cmode[k] = 1'b0; cval[k] = 8'hF0; gtick[k] = -1; gval[k] = 8'h00;
        end
    endtask

    task automatic clear_stats();
        cyc = 0;
        for (int k = 0; k < NCH; k++) begin
            bs_cnt[k] = 0; lock_tick[k] = -1; fail_tick[k] = -1; lol_cnt[k] = 0;
        end
        drive_data();
    endtask

    // After this, EN is first sampled at the edge counted as tick 1
    task automatic start_run();
        rst = 1'b1;
        bus.EN = 1'b0;
        tick();
        rst = 1'b0;
        clear_stats();
        bus.EN = 1'b1;
    endtask

    task automatic test_reset();
        default_cfg();
        clear_stats();
        rst = 1'b1;
        bus.EN = 1'b1;
        ticks(3);
        total++; if (bus.BS !== 4'h0) $display("FAIL reset_bs: got %h expected 0", bus.BS); else passed++;
        total++; if (bus.locked !== 4'h0) $display("FAIL reset_locked: got %h expected 0", bus.locked); else passed++;
        total++; if (bus.fail !== 4'h0) $display("FAIL reset_fail: got %h expected 0", bus.fail); else passed++;
        total++; if (bus.lol !== 4'h0) $display("FAIL reset_lol: got %h expected 0", bus.lol); else passed++;
        total++; if (bus.all_locked !== 1'b0) $display("FAIL reset_all_locked: got %b expected 0", bus.all_locked); else passed++;
        total++; if (bus.any_fail !== 1'b0) $display("FAIL reset_any_fail: got %b expected 0", bus.any_fail); else passed++;
    endtask

    task automatic test_aligned();
        default_cfg();
        start_run();
        ticks(4);
        total++; if (bus.locked !== 4'h0) $display("FAIL aligned_early: got %h expected 0", bus.locked); else passed++;
        tick();
        total++; if (bus.locked !== 4'hF) $display("FAIL aligned_locked: got %h expected f", bus.locked); else passed++;
        total++; if (bus.all_locked !== 1'b1) $display("FAIL aligned_all_locked: got %b expected 1", bus.all_locked); else passed++;
        ticks(10);
        total++;
        if (bs_cnt[0] + bs_cnt[1] + bs_cnt[2] + bs_cnt[3] !== 0)
            $display("FAIL aligned_no_bs: got %0d pulses expected 0", bs_cnt[0] + bs_cnt[1] + bs_cnt[2] + bs_cnt[3]);
        else passed++;
        total++; if (bus.locked !== 4'hF) $display("FAIL aligned_hold: got %h expected f", bus.locked); else passed++;
    endtask

    task automatic test_rotation();
        default_cfg();
        rot[2] = 5;
        start_run();
        ticks(40);
        total++; if (bs_cnt[2] !== 3) $display("FAIL rot_pulses: got %0d expected 3", bs_cnt[2]); else passed++;
        total++; if (pulse_tick[2][0] !== 2) $display("FAIL rot_p0: got %0d expected 2", pulse_tick[2][0]); else passed++;
        total++; if (pulse_tick[2][1] !== 9) $display("FAIL rot_p1: got %0d expected 9", pulse_tick[2][1]); else passed++;
        total++; if (pulse_tick[2][2] !== 16) $display("FAIL rot_p2: got %0d expected 16", pulse_tick[2][2]); else passed++;
        total++; if (lock_tick[2] !== 26) $display("FAIL rot_lock_tick: got %0d expected 26", lock_tick[2]); else passed++;
        total++; if (lock_tick[0] !== 5) $display("FAIL rot_other_lock: got %0d expected 5", lock_tick[0]); else passed++;
        total++; if (bs_cnt[0] + bs_cnt[1] + bs_cnt[3] !== 0) $display("FAIL rot_other_bs: got %0d expected 0", bs_cnt[0] + bs_cnt[1] + bs_cnt[3]); else passed++;
        total++; if (bus.all_locked !== 1'b1) $display("FAIL rot_all_locked: got %b expected 1", bus.all_locked); else passed++;
    endtask

    task automatic test_fail();
        default_cfg();
        cmode[0] = 1'b1;
        cval[0]  = 8'h00;
        start_run();
        ticks(140);
        total++; if (bs_cnt[0] !== 16) $display("FAIL fail_pulses: got %0d expected 16", bs_cnt[0]); else passed++;
        total++; if (pulse_tick[0][15] !== 107) $display("FAIL fail_last_pulse: got %0d expected 107", pulse_tick[0][15]); else passed++;
        total++; if (fail_tick[0] !== 114) $display("FAIL fail_tick: got %0d expected 114", fail_tick[0]); else passed++;
        total++; if (bus.fail !== 4'b0001) $display("FAIL fail_flags: got %b expected 0001", bus.fail); else passed++;
        total++; if (bus.any_fail !== 1'b1) $display("FAIL fail_any: got %b expected 1", bus.any_fail); else passed++;
        total++; if (bus.locked !== 4'b1110) $display("FAIL fail_locked: got %b expected 1110", bus.locked); else passed++;
        total++; if (bus.all_locked !== 1'b0) $display("FAIL fail_all_locked: got %b expected 0", bus.all_locked); else passed++;
    endtask

    task automatic test_broken_run();
        default_cfg();
        cmode[1] = 1'b1;
        cval[1]  = 8'hF0;
        gtick[1] = 4;
        gval[1]  = 8'h00;
        start_run();
        ticks(30);
        total++; if (bs_cnt[1] !== 1) $display("FAIL broken_pulses: got %0d expected 1", bs_cnt[1]); else passed++;
        total++; if (pulse_tick[1][0] !== 5) $display("FAIL broken_pulse_tick: got %0d expected 5", pulse_tick[1][0]); else passed++;
        total++; if (lock_tick[1] !== 15) $display("FAIL broken_lock_tick: got %0d expected 15", lock_tick[1]); else passed++;
    endtask

    task automatic test_abort();
        default_cfg();
        cmode[0] = 1'b1;
        cval[0]  = 8'h00;
        start_run();
        ticks(2);
        total++; if (bus.BS[0] !== 1'b1) $display("FAIL abort_slip_seen: got %b expected 1", bus.BS[0]); else passed++;
        rst = 1'b1;
        tick();
        total++; if (bus.BS !== 4'h0) $display("FAIL abort_rst_bs: got %h expected 0", bus.BS); else passed++;
        total++; if (bus.locked !== 4'h0) $display("FAIL abort_rst_locked: got %h expected 0", bus.locked); else passed++;
        start_run();
        ticks(6);
        total++; if (bus.locked !== 4'b1110) $display("FAIL abort_pre_locked: got %b expected 1110", bus.locked); else passed++;
        bus.EN = 1'b0;
        tick();
        total++; if (bus.BS !== 4'h0) $display("FAIL abort_en_bs: got %h expected 0", bus.BS); else passed++;
        total++; if (bus.locked !== 4'h0) $display("FAIL abort_en_locked: got %h expected 0", bus.locked); else passed++;
        total++; if (bus.fail !== 4'h0) $display("FAIL abort_en_fail: got %h expected 0", bus.fail); else passed++;
        clear_stats();
        bus.EN = 1'b1;
        ticks(130);
        total++; if (bs_cnt[0] !== 16) $display("FAIL abort_restart_pulses: got %0d expected 16", bs_cnt[0]); else passed++;
        total++; if (fail_tick[0] !== 114) $display("FAIL abort_restart_fail_tick: got %0d expected 114", fail_tick[0]); else passed++;
    endtask

    task automatic test_loss_of_lock();
        default_cfg();
        start_run();
        ticks(5);
        total++; if (bus.locked !== 4'hF) $display("FAIL lol_pre_locked: got %h expected f", bus.locked); else passed++;
        cmode[3] = 1'b1;
        cval[3]  = 8'h0F;
        drive_data();
`ifdef LOSS_OF_LOCK_EN
        ticks(7);
        cval[3] = 8'hF0;
        drive_data();
        tick();
        total++; if (bus.locked[3] !== 1'b1) $display("FAIL lol_seven_locked: got %b expected 1", bus.locked[3]); else passed++;
        total++; if (lol_cnt[3] !== 0) $display("FAIL lol_seven_pulses: got %0d expected 0", lol_cnt[3]); else passed++;
        cval[3] = 8'h0F;
        drive_data();
        ticks(8);
        total++; if (bus.lol[3] !== 1'b1) $display("FAIL lol_pulse: got %b expected 1", bus.lol[3]); else passed++;
        total++; if (bus.locked[3] !== 1'b0) $display("FAIL lol_unlocked: got %b expected 0", bus.locked[3]); else passed++;
        tick();
        total++; if (bus.lol[3] !== 1'b0) $display("FAIL lol_single_cycle: got %b expected 0", bus.lol[3]); else passed++;
        total++; if (bus.BS[3] !== 1'b1) $display("FAIL lol_realign_slip: got %b expected 1", bus.BS[3]); else passed++;
        total++; if (bus.locked[2:0] !== 3'b111) $display("FAIL lol_others: got %b expected 111", bus.locked[2:0]); else passed++;
`else
        ticks(12);
        total++; if (bus.locked !== 4'hF) $display("FAIL lol_terminal_locked: got %h expected f", bus.locked); else passed++;
        total++; if (lol_cnt[3] !== 0) $display("FAIL lol_tied_zero: got %0d expected 0", lol_cnt[3]); else passed++;
        total++; if (bs_cnt[3] !== 0) $display("FAIL lol_no_slip: got %0d expected 0", bs_cnt[3]); else passed++;
`endif
    endtask

    initial begin
        bus.EN = 1'b0;
        bus.data_in = '0;
        test_reset();
        test_aligned();
        test_rotation();
        test_fail();
        test_broken_run();
        test_abort();
        test_loss_of_lock();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bitslip_align_multi.md
Name: bitslip_align_multi

Overview:
Multi-channel, parametrised word aligner for ISERDESE2 deserialisers. Each channel compares its deserialised word against a training pattern and issues single-cycle BITSLIP pulses, spaced by a programmable settle time, until it sees the pattern on a required number of consecutive words. Per-channel lock/fail status is aggregated for the link-bring-up controller. Sits between the ISERDESE2 bank and the downstream frame/data logic.

Parameters:
WIDTH, 8, deserialised word width in bits (ISERDESE2 DATA_WIDTH)
NCH, 4, number of independent channels
TRAINING_PATTERN, 8'hF0, WIDTH-bit pattern each channel must align to
WAIT_CYCLES, 5, settle cycles after each bitslip before comparison resumes (>=1)
MATCH_COUNT, 4, consecutive matching words required to declare lock (>=1)
MAX_SLIPS, 16, bitslips allowed before a channel declares failure (>=WIDTH)
LOL_THRESH, 8, consecutive mismatches in lock that trigger re-alignment (used only with LOSS_OF_LOCK_EN)

Ports:
clk  input  1  deserialiser parallel clock (CLKDIV domain)
rst  input  1  synchronous, active-high reset
EN  input  1  alignment enable; low forces all channels to IDLE
data_in  input  NCH*WIDTH  channel k word at [k*WIDTH +: WIDTH]
BS  output  NCH  per-channel BITSLIP to ISERDESE2, registered
locked  output  NCH  per-channel aligned flag, registered
fail  output  NCH  per-channel alignment failure flag, registered
all_locked  output  1  AND of locked
any_fail  output  1  OR of fail
lol  output  NCH  per-channel single-cycle loss-of-lock pulse (tied 0 without macro)

Behaviour:
- Reset (rst=1 on a clk edge): all channels IDLE; BS, locked, fail, lol = 0; all counters 0. rst has priority over EN.
- EN=0 (rst=0): same as reset, every cycle. EN dropping mid-operation aborts immediately; BS never held high.
- Per-channel FSM, channels fully independent, registered outputs (Moore):
- IDLE: if EN=1 -> CHECK next cycle.
- CHECK: data==pattern: match_cnt+1; when match_cnt reaches MATCH_COUNT -> LOCKED. Mismatch: match_cnt=0; if slip_cnt==MAX_SLIPS -> FAIL, else -> SLIP.
- SLIP: BS=1 for exactly this one cycle; slip_cnt+1; wait_cnt=0 -> WAIT.
- WAIT: BS=0; data ignored; after WAIT_CYCLES cycles -> CHECK.
- LOCKED: locked=1; holds (terminal without macro) until EN=0 or rst.
- FAIL: fail=1; BS=0; holds until EN=0 or rst.
- Outputs reflect current state: BS high only in SLIP, locked only in LOCKED, fail only in FAIL.
- Timing: first compare in first CHECK cycle after IDLE; minimum BS pulse spacing = WAIT_CYCLES+2 cycles. Channel already aligned: locked asserts MATCH_COUNT+1 cycles after EN rises (IDLE cycle + MATCH_COUNT checks).
- Match run broken by one mismatch restarts at 0 and triggers a slip.
- Counters: slip_cnt width clog2(MAX_SLIPS+1), wait_cnt clog2(WAIT_CYCLES+1), match_cnt clog2(MATCH_COUNT+1); saturate, never wrap.
- all_locked, any_fail: combinational from registered flags.

Optional Feature:
LOSS_OF_LOCK_EN: when defined, LOCKED monitors data_in; each mismatch increments err_cnt, each match clears it; at LOL_THRESH consecutive mismatches channel clears locked, pulses lol for one cycle, resets slip_cnt/match_cnt, -> CHECK (re-alignment with fresh slip budget). Not defined: LOCKED terminal, data ignored in LOCKED, lol constant 0, no err_cnt logic.

Test Plan:
- Aligned: WIDTH=8, NCH=4, pattern 8'hF0, all channels 8'hF0, EN 0->1 -> no BS pulses, locked=4'hF and all_locked=1 exactly 5 cycles after EN rise.
- Rotation: ch2 model needs 3 slips (word rotates by 1 per BS) -> BS[2] pulses 3 times, spaced 7 cycles, then locked[2]=1; other channels unaffected.
- Fail: ch0 constant 8'h00 -> exactly 16 BS[0] pulses, then fail[0]=1, any_fail=1, BS[0] stays 0.
- Broken run: ch1 sends F0,F0,F0,00,F0... -> match_cnt restarts, one BS[1] pulse issued, lock only after 4 consecutive F0 post-WAIT.
- Abort: rst=1 (or EN=0) during SLIP/WAIT -> next cycle BS=0, locked=0, fail=0; re-enable restarts from IDLE with slip_cnt=0.
- LOSS_OF_LOCK_EN: locked ch3 receives 8 consecutive 8'h0F -> lol[3] one-cycle pulse, locked[3]=0, re-alignment begins; 7 mismatches then F0 -> stays locked.
